// File: rtl/sync_filt_edge.sv
// Multi-channel input synchronizer: flop chain, optional stability filter, and
// single-cycle rise/fall pulses, all in the destination clock domain.
module sync_filt_edge #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter int             FILT    = 0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic         chg
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_filt_edge: STAGES must be >= 2");
        end
    endgenerate

    // Only the d -> s[0] path crosses domains; s[] is the synchronizer proper.
    logic [W-1:0] s [STAGES];
    logic [W-1:0] sy;
    logic [W-1:0] q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) s[i] <= RST_VAL;
        end else begin
            s[0] <= d;
            for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
        end
    end

    assign sy = s[STAGES-1];

    generate
        if (FILT == 0) begin : g_nofilt
            assign q = sy;
        end else begin : g_filt
            localparam int CW = $clog2(FILT + 1);
            for (genvar c = 0; c < W; c++) begin : g_ch
                logic [CW-1:0] cnt;
                logic          q_r;

                // q only follows sy after FILT consecutive cycles of disagreement.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt <= '0;
                        q_r <= RST_VAL[c];
                    end else if (sy[c] == q_r) begin
                        cnt <= '0;
                    end else if (cnt == CW'(FILT - 1)) begin
                        cnt <= '0;
                        q_r <= sy[c];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                assign q[c] = q_r;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_d <= RST_VAL;
        else     q_d <= q;
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
    assign chg  = |(rise | fall);

endmodule

// File: tb/tb_sync_filt_edge.sv
// Self-checking bench for sync_filt_edge: directed scenarios on several parameter
// sets plus a random multi-channel run against a scoreboard/reference model.
module tb_sync_filt_edge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] d_a, q_a, rise_a, fall_a; logic chg_a;
    logic [3:0] d_b, q_b, rise_b, fall_b; logic chg_b;
    logic [1:0] d_c, q_c, rise_c, fall_c; logic chg_c;
    logic [1:0] d_m, q_m, rise_m, fall_m; logic chg_m;
    logic [7:0] d_e, q_e, rise_e, fall_e; logic chg_e;
    logic [7:0] d_f, q_f, rise_f, fall_f; logic chg_f;

    sync_filt_edge #(.W(4), .STAGES(2), .FILT(0), .RST_VAL(4'b1010)) u_a (
        .clk(clk), .rst(rst), .d(d_a), .q(q_a), .rise(rise_a), .fall(fall_a), .chg(chg_a));
    sync_filt_edge #(.W(4), .STAGES(3), .FILT(0), .RST_VAL(4'b0000)) u_b (
        .clk(clk), .rst(rst), .d(d_b), .q(q_b), .rise(rise_b), .fall(fall_b), .chg(chg_b));
    sync_filt_edge #(.W(2), .STAGES(2), .FILT(4), .RST_VAL(2'b00)) u_c (
        .clk(clk), .rst(rst), .d(d_c), .q(q_c), .rise(rise_c), .fall(fall_c), .chg(chg_c));
    sync_filt_edge #(.W(2), .STAGES(2), .FILT(8), .RST_VAL(2'b00)) u_m (
        .clk(clk), .rst(rst), .d(d_m), .q(q_m), .rise(rise_m), .fall(fall_m), .chg(chg_m));
    sync_filt_edge #(.W(8), .STAGES(2), .FILT(0), .RST_VAL(8'h00)) u_e (
        .clk(clk), .rst(rst), .d(d_e), .q(q_e), .rise(rise_e), .fall(fall_e), .chg(chg_e));
    sync_filt_edge #(.W(8), .STAGES(2), .FILT(3), .RST_VAL(8'h00)) u_f (
        .clk(clk), .rst(rst), .d(d_f), .q(q_f), .rise(rise_f), .fall(fall_f), .chg(chg_f));

    task automatic test_reset();
        logic [3:0] eq, ef;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({q_a, rise_a, fall_a, chg_a} !== {4'b1010, 4'b0000, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold k=%0d: got q=%b rise=%b fall=%b chg=%b, want q=1010 rise=0000 fall=0000 chg=0",
                         k, q_a, rise_a, fall_a, chg_a);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            eq = (k >= 2) ? 4'b0000 : 4'b1010;
            ef = (k == 2) ? 4'b1010 : 4'b0000;
            checks++;
            if ({q_a, rise_a, fall_a, chg_a} !== {eq, 4'b0000, ef, (k == 2)}) begin
                errors++;
                $display("FAIL reset_release k=%0d: got q=%b rise=%b fall=%b chg=%b, want q=%b rise=0000 fall=%b chg=%b",
                         k, q_a, rise_a, fall_a, chg_a, eq, ef, (k == 2));
            end
        end
    endtask

    task automatic test_latency();
        d_b = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({q_b[0], rise_b[0], fall_b[0]} !== {(k >= 3), (k == 3), 1'b0}) begin
                errors++;
                $display("FAIL latency k=%0d: got q=%b rise=%b fall=%b, want q=%b rise=%b fall=0",
                         k, q_b[0], rise_b[0], fall_b[0], (k >= 3), (k == 3));
            end
        end
        d_b = 4'b0000;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_filter();
        int lens[2] = '{3, 4};
        logic eq, er, ef;
        foreach (lens[j]) begin
            d_c[0] = 1'b1;
            for (int k = 1; k <= 14; k++) begin
                @(posedge clk); #1;
                if (k == lens[j]) d_c[0] = 1'b0;
                eq = (lens[j] >= 4) && (k >= 6) && (k < 6 + lens[j]);
                er = (lens[j] >= 4) && (k == 6);
                ef = (lens[j] >= 4) && (k == 6 + lens[j]);
                checks++;
                if ({q_c[0], rise_c[0], fall_c[0]} !== {eq, er, ef}) begin
                    errors++;
                    $display("FAIL filter len=%0d k=%0d: got q=%b rise=%b fall=%b, want q=%b rise=%b fall=%b",
                             lens[j], k, q_c[0], rise_c[0], fall_c[0], eq, er, ef);
                end
            end
        end
    endtask

    task automatic test_chatter();
        int pat[7] = '{1, 0, 1, 1, 1, 1, 1};
        d_c[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({q_c[0], rise_c[0]} !== {(k >= 8), (k == 8)}) begin
                errors++;
                $display("FAIL chatter k=%0d: got q=%b rise=%b, want q=%b rise=%b",
                         k, q_c[0], rise_c[0], (k >= 8), (k == 8));
            end
            d_c[0] = (k < 7) ? (pat[k] != 0) : 1'b1;
        end
        d_c[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (q_c !== 2'b00) begin
            errors++;
            $display("FAIL chatter_settle: got q=%b, want q=00", q_c);
        end
    endtask

    task automatic test_mid_reset();
        d_m[1] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (q_m !== 2'b00) begin
            errors++;
            $display("FAIL mid_count: got q=%b, want q=00", q_m);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({q_m, rise_m, fall_m, chg_m} !== {2'b00, 2'b00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_m: got q=%b rise=%b fall=%b chg=%b, want q=00 rise=00 fall=00 chg=0",
                     q_m, rise_m, fall_m, chg_m);
        end
        checks++;
        if ({q_a, rise_a, fall_a, chg_a} !== {4'b1010, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: got q=%b rise=%b fall=%b chg=%b, want q=1010 rise=0000 fall=0000 chg=0",
                     q_a, rise_a, fall_a, chg_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({q_m[1], rise_m[1], fall_m[1]} !== {(k >= 10), (k == 10), 1'b0}) begin
                errors++;
                $display("FAIL mid_reset_relat k=%0d: got q=%b rise=%b fall=%b, want q=%b rise=%b fall=0",
                         k, q_m[1], rise_m[1], fall_m[1], (k >= 10), (k == 10));
            end
        end
        d_m = 2'b00;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_multi();
        logic [7:0] eq, er, ef;
        d_e = 8'hFF;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            eq = (k >= 2) ? 8'hFF : 8'h00;
            er = (k == 2) ? 8'hFF : 8'h00;
            checks++;
            if ({q_e, rise_e, fall_e, chg_e} !== {eq, er, 8'h00, (k == 2)}) begin
                errors++;
                $display("FAIL multi_rise k=%0d: got q=%h rise=%h fall=%h chg=%b, want q=%h rise=%h fall=00 chg=%b",
                         k, q_e, rise_e, fall_e, chg_e, eq, er, (k == 2));
            end
        end
        d_e = 8'h0F;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            eq = (k >= 2) ? 8'h0F : 8'hFF;
            ef = (k == 2) ? 8'hF0 : 8'h00;
            checks++;
            if ({q_e, rise_e, fall_e, chg_e} !== {eq, 8'h00, ef, (k == 2)}) begin
                errors++;
                $display("FAIL multi_fall k=%0d: got q=%h rise=%h fall=%h chg=%b, want q=%h rise=00 fall=%h chg=%b",
                         k, q_e, rise_e, fall_e, chg_e, eq, ef, (k == 2));
            end
        end
        d_e = 8'h00;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] dr, mask, sy, sy_prev, qe_prev, qf, qf_new, er, ef;
        int run[8];
        dr = 8'h00; sy_prev = 8'h00; qe_prev = 8'h00; qf = 8'h00;
        foreach (run[b]) run[b] = 0;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 10000; i++) begin
            mask = ((i % 500) < 50) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            dr = dr ^ mask;
            d_e = dr;
            d_f = dr;
            exp_q.push_back(dr);
            @(posedge clk); #1;
            sy = exp_q.pop_front();

            er = sy & ~qe_prev;
            ef = ~sy & qe_prev;
            checks++;
            if ({q_e, rise_e, fall_e, chg_e} !== {sy, er, ef, |(er | ef)}) begin
                errors++;
                $display("FAIL random_nofilt i=%0d: got q=%h rise=%h fall=%h chg=%b, want q=%h rise=%h fall=%h chg=%b",
                         i, q_e, rise_e, fall_e, chg_e, sy, er, ef, |(er | ef));
            end
            qe_prev = sy;

            qf_new = qf;
            for (int b = 0; b < 8; b++) begin
                if (sy_prev[b] != qf[b]) begin
                    run[b]++;
                    if (run[b] == 3) begin
                        qf_new[b] = sy_prev[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            er = qf_new & ~qf;
            ef = ~qf_new & qf;
            checks++;
            if ({q_f, rise_f, fall_f, chg_f} !== {qf_new, er, ef, |(er | ef)}) begin
                errors++;
                $display("FAIL random_filt i=%0d: got q=%h rise=%h fall=%h chg=%b, want q=%h rise=%h fall=%h chg=%b",
                         i, q_f, rise_f, fall_f, chg_f, qf_new, er, ef, |(er | ef));
            end
            qf = qf_new;
            sy_prev = sy;
        end
    endtask

    initial begin
        rst = 1'b1;
        d_a = '0; d_b = '0; d_c = '0; d_m = '0; d_e = '0; d_f = '0;
        test_reset();
        repeat (4) @(posedge clk);
        #1;
        test_latency();
        test_filter();
        test_chatter();
        test_mid_reset();
        test_multi();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
